// File: rtl/iir_biquad_tdm_if.sv
// Sample/result handshake bundle for the time-multiplexed biquad.
// The slave side is the filter; the master side is the upstream/downstream pair.
interface iir_biquad_tdm_if #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned COEF_W = 24,
  parameter int unsigned CH_W   = 2
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic        [CH_W-1:0]   in_ch;
  logic signed [COEF_W-1:0] b0;
  logic signed [COEF_W-1:0] b1;
  logic signed [COEF_W-1:0] b2;
  logic signed [COEF_W-1:0] a1;
  logic signed [COEF_W-1:0] a2;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic        [CH_W-1:0]   out_ch;

  modport master (
    output in_valid, in_data, in_ch, b0, b1, b2, a1, a2, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, in_ch, b0, b1, b2, a1, a2, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/iir_biquad_tdm.sv
// Direct-Form-II biquad shared across NUM_CH channels with a single multiplier.
// One sample is processed at a time over six arithmetic steps, then held until taken.
module iir_biquad_tdm #(
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned COEF_W    = 24,
  parameter int unsigned COEF_FRAC = 22,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  output logic              sat_flag,
  iir_biquad_tdm_if.slave   bus
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = PROD_W + 3;

  localparam logic signed [DATA_W-1:0] DMax     = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] DMin     = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0]  RndHalf  = {{(ACC_W-1){1'b0}}, 1'b1} << (COEF_FRAC - 1);

  typedef enum logic [2:0] {
    StIdle, StFb1, StFb2, StW0, StFf0, StFf1, StFf2, StOut
  } state_e;

  state_e                   state_q;
  logic signed [DATA_W-1:0] x_q, w0_q, w1_q, w2_q;
  logic        [CH_W-1:0]   ch_q;
  logic signed [COEF_W-1:0] b0_q, b1_q, b2_q, a1_q, a2_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [DATA_W-1:0] w1_mem [NUM_CH];
  logic signed [DATA_W-1:0] w2_mem [NUM_CH];

  logic signed [DATA_W-1:0] rd_w1, rd_w2;
  logic signed [DATA_W-1:0] mul_d;
  logic signed [COEF_W-1:0] mul_c;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext, x_ext, acc_sum, rnd_in, rnd_sh;
  logic                     sat_hi, sat_lo;
  logic signed [DATA_W-1:0] sat_val;

  // Out-of-range channels read as zero state and never match a write-back slot.
  always_comb begin
    rd_w1 = '0;
    rd_w2 = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (bus.in_ch == CH_W'(i)) begin
        rd_w1 = w1_mem[i];
        rd_w2 = w2_mem[i];
      end
    end
  end

  always_comb begin
    mul_d = '0;
    mul_c = '0;
    case (state_q)
      StFb1: begin mul_d = w1_q; mul_c = a1_q; end
      StFb2: begin mul_d = w2_q; mul_c = a2_q; end
      StFf0: begin mul_d = w0_q; mul_c = b0_q; end
      StFf1: begin mul_d = w1_q; mul_c = b1_q; end
      StFf2: begin mul_d = w2_q; mul_c = b2_q; end
      default: ;
    endcase
  end

  assign prod = PROD_W'(mul_d) * PROD_W'(mul_c);

  // One rounder/saturator serves both w0 (from acc) and y (from the final sum).
  always_comb begin
    prod_ext = ACC_W'(prod);
    x_ext    = ACC_W'(x_q) <<< COEF_FRAC;
    case (state_q)
      StFb1:   acc_sum = x_ext - prod_ext;
      StFb2:   acc_sum = acc_q - prod_ext;
      StFf0:   acc_sum = prod_ext;
      default: acc_sum = acc_q + prod_ext;
    endcase
    rnd_in = (state_q == StFf2) ? acc_sum : acc_q;
    rnd_sh = (rnd_in + RndHalf) >>> COEF_FRAC;
    sat_hi = rnd_sh > ACC_W'(DMax);
    sat_lo = rnd_sh < ACC_W'(DMin);
    if (sat_hi) begin
      sat_val = DMax;
    end else if (sat_lo) begin
      sat_val = DMin;
    end else begin
      sat_val = rnd_sh[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      sat_flag      <= 1'b0;
      x_q           <= '0;
      w0_q          <= '0;
      w1_q          <= '0;
      w2_q          <= '0;
      ch_q          <= '0;
      b0_q          <= '0;
      b1_q          <= '0;
      b2_q          <= '0;
      a1_q          <= '0;
      a2_q          <= '0;
      acc_q         <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        w1_mem[i] <= '0;
        w2_mem[i] <= '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid && bus.in_ready) begin
            x_q          <= bus.in_data;
            ch_q         <= bus.in_ch;
            b0_q         <= bus.b0;
            b1_q         <= bus.b1;
            b2_q         <= bus.b2;
            a1_q         <= bus.a1;
            a2_q         <= bus.a2;
            w1_q         <= rd_w1;
            w2_q         <= rd_w2;
            bus.in_ready <= 1'b0;
            state_q      <= StFb1;
          end else begin
            bus.in_ready <= 1'b1;
          end
        end
        StFb1: begin acc_q <= acc_sum; state_q <= StFb2; end
        StFb2: begin acc_q <= acc_sum; state_q <= StW0;  end
        StW0:  begin w0_q  <= sat_val; state_q <= StFf0; end
        StFf0: begin acc_q <= acc_sum; state_q <= StFf1; end
        StFf1: begin acc_q <= acc_sum; state_q <= StFf2; end
        StFf2: begin
          acc_q         <= acc_sum;
          bus.out_data  <= sat_val;
          bus.out_ch    <= ch_q;
          bus.out_valid <= 1'b1;
          state_q       <= StOut;
        end
        StOut: begin
          if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // clear takes priority over a coincident write-back or saturation event.
      if (clear) begin
        sat_flag <= 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
          w1_mem[i] <= '0;
          w2_mem[i] <= '0;
        end
      end else begin
        if ((state_q == StW0 || state_q == StFf2) && (sat_hi || sat_lo)) begin
          sat_flag <= 1'b1;
        end
        if (state_q == StFf2) begin
          for (int i = 0; i < int'(NUM_CH); i++) begin
            if (ch_q == CH_W'(i)) begin
              w2_mem[i] <= w1_q;
              w1_mem[i] <= w0_q;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_iir_biquad_tdm.sv
// Bench for iir_biquad_tdm: directed scenarios plus random samples against an integer
// reference of the biquad difference equations.
module tb_iir_biquad_tdm;
  localparam int DW   = 24;
  localparam int CW   = 24;
  localparam int FRAC = 22;
  localparam int NCH  = 4;
  localparam int CHW  = 2;
  localparam longint ONE = 64'sd4194304;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic sat_flag;

  iir_biquad_tdm_if #(.DATA_W(DW), .COEF_W(CW), .CH_W(CHW)) bus ();

  iir_biquad_tdm #(
    .DATA_W(DW), .COEF_W(CW), .COEF_FRAC(FRAC), .NUM_CH(NCH), .CH_W(CHW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .sat_flag(sat_flag),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  longint mw1[NCH];
  longint mw2[NCH];
  bit     msat;

  function automatic longint model_rs(input longint acc);
    longint r;
    r = (acc + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
    if (r > 8388607) begin
      r = 8388607;
      msat = 1'b1;
    end else if (r < -8388608) begin
      r = -8388608;
      msat = 1'b1;
    end
    return r;
  endfunction

  function automatic void model_zero();
    for (int i = 0; i < NCH; i++) begin
      mw1[i] = 0;
      mw2[i] = 0;
    end
    msat = 1'b0;
  endfunction

  function automatic longint model_step(input longint x, input int ch, input longint c0,
                                        input longint c1, input longint c2, input longint d1,
                                        input longint d2);
    longint w1 = 0;
    longint w2 = 0;
    longint w0, y;
    if (ch < NCH) begin
      w1 = mw1[ch];
      w2 = mw2[ch];
    end
    w0 = model_rs(x * ONE - d1 * w1 - d2 * w2);
    y  = model_rs(c0 * w0 + c1 * w1 + c2 * w2);
    if (ch < NCH) begin
      mw2[ch] = w1;
      mw1[ch] = w0;
    end
    return y;
  endfunction

  function automatic logic [23:0] rnd24();
    logic [31:0] r;
    r = $urandom;
    return r[23:0];
  endfunction

  task automatic accept(input longint x, input int ch, input longint c0, input longint c1,
                        input longint c2, input longint d1, input longint d2);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = x[DW-1:0];
    bus.in_ch    = ch[CHW-1:0];
    bus.b0 = c0[CW-1:0];
    bus.b1 = c1[CW-1:0];
    bus.b2 = c2[CW-1:0];
    bus.a1 = d1[CW-1:0];
    bus.a2 = d2[CW-1:0];
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = rnd24();
    bus.b0 = rnd24();
    bus.b1 = rnd24();
    bus.b2 = rnd24();
    bus.a1 = rnd24();
    bus.a2 = rnd24();
  endtask

  task automatic send(input longint x, input int ch, input longint c0, input longint c1,
                      input longint c2, input longint d1, input longint d2,
                      output longint y, output int och, output int lat);
    accept(x, ch, c0, c1, c2, d1, d2);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
    y   = bus.out_data;
    och = int'(bus.out_ch);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_zero();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 24'sd0) begin errors++; $display("FAIL reset_out_data: got %0d want 0", bus.out_data); end
    checks++; if (bus.out_ch !== 2'd0) begin errors++; $display("FAIL reset_out_ch: got %0d want 0", bus.out_ch); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag: got %b want 0", sat_flag); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", bus.in_ready); end
    model_zero();
  endtask

  task automatic test_passthrough();
    longint y, e;
    int och, lat;
    send(1000, 0, ONE, 0, 0, 0, 0, y, och, lat);
    e = model_step(1000, 0, ONE, 0, 0, 0, 0);
    checks++; if (y !== e) begin errors++; $display("FAIL pass_data: got %0d want %0d", y, e); end
    checks++; if (och !== 0) begin errors++; $display("FAIL pass_ch: got %0d want 0", och); end
    checks++; if (lat !== 6) begin errors++; $display("FAIL pass_latency: got %0d want 6", lat); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL pass_sat: got %b want 0", sat_flag); end
  endtask

  task automatic test_recursion();
    int tab[5] = '{4096, 2048, 1024, 512, 256};
    longint y, e;
    int och, lat;
    pulse_clear();
    for (int i = 0; i < 5; i++) begin
      send((i == 0) ? 4096 : 0, 0, ONE, 0, 0, -ONE / 2, 0, y, och, lat);
      e = model_step((i == 0) ? 4096 : 0, 0, ONE, 0, 0, -ONE / 2, 0);
      checks++; if (y !== longint'(tab[i])) begin errors++; $display("FAIL recur_%0d: got %0d want %0d", i, y, tab[i]); end
    end
  endtask

  task automatic test_isolation();
    int tab[5] = '{4096, 2048, 1024, 512, 256};
    longint y, e;
    int och, lat;
    pulse_clear();
    send(12345, 3, ONE, 0, 0, -ONE / 2, 0, y, och, lat);
    e = model_step(12345, 3, ONE, 0, 0, -ONE / 2, 0);
    for (int i = 0; i < 5; i++) begin
      send((i == 0) ? 4096 : 0, 0, ONE, 0, 0, -ONE / 2, 0, y, och, lat);
      e = model_step((i == 0) ? 4096 : 0, 0, ONE, 0, 0, -ONE / 2, 0);
      checks++; if (y !== longint'(tab[i])) begin errors++; $display("FAIL iso_ch0_%0d: got %0d want %0d", i, y, tab[i]); end
      send(0, 1, ONE, 0, 0, -ONE / 2, 0, y, och, lat);
      e = model_step(0, 1, ONE, 0, 0, -ONE / 2, 0);
      checks++; if (y !== e || och !== 1) begin errors++; $display("FAIL iso_ch1_%0d: got %0d/ch%0d want %0d/ch1", i, y, och, e); end
    end
    send(0, 3, ONE, 0, 0, -ONE / 2, 0, y, och, lat);
    e = model_step(0, 3, ONE, 0, 0, -ONE / 2, 0);
    checks++; if (y !== e) begin errors++; $display("FAIL iso_ch3: got %0d want %0d", y, e); end
  endtask

  task automatic test_saturation();
    longint y, e;
    int och, lat;
    send(6000000, 2, 6291456, 0, 0, 0, 0, y, och, lat);
    e = model_step(6000000, 2, 6291456, 0, 0, 0, 0);
    checks++; if (y !== e) begin errors++; $display("FAIL sat_pos: got %0d want %0d", y, e); end
    checks++; if (sat_flag !== msat) begin errors++; $display("FAIL sat_flag_set: got %b want %b", sat_flag, msat); end
    send(-6000000, 2, 6291456, 0, 0, 0, 0, y, och, lat);
    e = model_step(-6000000, 2, 6291456, 0, 0, 0, 0);
    checks++; if (y !== e) begin errors++; $display("FAIL sat_neg: got %0d want %0d", y, e); end
    send(100, 2, ONE, 0, 0, 0, 0, y, och, lat);
    e = model_step(100, 2, ONE, 0, 0, 0, 0);
    checks++; if (y !== e) begin errors++; $display("FAIL sat_after: got %0d want %0d", y, e); end
    checks++; if (sat_flag !== msat) begin errors++; $display("FAIL sat_sticky: got %b want %b", sat_flag, msat); end
    pulse_clear();
    checks++; if (sat_flag !== msat) begin errors++; $display("FAIL sat_clear: got %b want %b", sat_flag, msat); end
  endtask

  task automatic test_backpressure();
    longint y, e;
    int och, lat;
    bit seen = 1'b0;
    bus.out_ready = 1'b0;
    accept(777, 1, ONE, 0, 0, -ONE / 2, 0);
    e = model_step(777, 1, ONE, 0, 0, -ONE / 2, 0);
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk);
      #1;
      seen = bus.out_valid;
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_valid_timeout: got 0 want 1"); end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || longint'(bus.out_data) !== e || bus.out_ch !== 2'd1 ||
          bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got v=%b d=%0d ch=%0d rdy=%b want v=1 d=%0d ch=1 rdy=0", k,
                 bus.out_valid, bus.out_data, bus.out_ch, bus.in_ready, e);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready); end
    send(0, 1, ONE, 0, 0, -ONE / 2, 0, y, och, lat);
    e = model_step(0, 1, ONE, 0, 0, -ONE / 2, 0);
    checks++; if (y !== e || lat !== 6) begin errors++; $display("FAIL bp_next: got %0d lat %0d want %0d lat 6", y, lat, e); end
  endtask

  task automatic test_clear_midop();
    int tab[3] = '{4096, 2048, 1024};
    longint y, e;
    int och, lat;
    accept(4096, 0, ONE, 0, 0, -ONE / 2, 0);
    e = model_step(4096, 0, ONE, 0, 0, -ONE / 2, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_zero();
    checks++;
    if (bus.out_valid !== 1'b1 || longint'(bus.out_data) !== e || bus.out_ch !== 2'd0) begin
      errors++;
      $display("FAIL clr_inflight: got v=%b d=%0d ch=%0d want v=1 d=%0d ch=0", bus.out_valid,
               bus.out_data, bus.out_ch, e);
    end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL clr_sat: got %b want 0", sat_flag); end
    for (int i = 0; i < 3; i++) begin
      send((i == 0) ? 4096 : 0, 0, ONE, 0, 0, -ONE / 2, 0, y, och, lat);
      e = model_step((i == 0) ? 4096 : 0, 0, ONE, 0, 0, -ONE / 2, 0);
      checks++; if (y !== longint'(tab[i])) begin errors++; $display("FAIL clr_restart_%0d: got %0d want %0d", i, y, tab[i]); end
    end
  endtask

  task automatic test_random();
    longint y, e, x, c0, c1, c2, d1, d2;
    int ch, och, lat;
    for (int i = 0; i < 60; i++) begin
      ch = int'($urandom_range(0, NCH - 1));
      x  = longint'($urandom_range(0, 16777215)) - 8388608;
      c0 = longint'($urandom_range(0, 2 * 4194304)) - ONE;
      c1 = longint'($urandom_range(0, 2 * 4194304)) - ONE;
      c2 = longint'($urandom_range(0, 2 * 4194304)) - ONE;
      d1 = longint'($urandom_range(0, 2 * 4194304)) - ONE;
      d2 = longint'($urandom_range(0, 4194304)) - ONE / 2;
      send(x, ch, c0, c1, c2, d1, d2, y, och, lat);
      e = model_step(x, ch, c0, c1, c2, d1, d2);
      checks++; if (y !== e) begin errors++; $display("FAIL rnd_data_%0d: got %0d want %0d", i, y, e); end
      checks++; if (och !== ch) begin errors++; $display("FAIL rnd_ch_%0d: got %0d want %0d", i, och, ch); end
      checks++; if (sat_flag !== msat) begin errors++; $display("FAIL rnd_sat_%0d: got %b want %b", i, sat_flag, msat); end
    end
  endtask

  task automatic test_reset_midop();
    longint y, e;
    int och, lat;
    bit seen = 1'b0;
    accept(5000, 2, ONE, ONE, ONE, -ONE / 2, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: got v=%b rdy=%b want 0/0", bus.out_valid, bus.in_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_zero();
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_output: got %b want 0", seen); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL rstmid_sat: got %b want 0", sat_flag); end
    for (int c = 0; c < NCH; c++) begin
      send(0, c, ONE, ONE, ONE, 0, 0, y, och, lat);
      e = model_step(0, c, ONE, ONE, ONE, 0, 0);
      checks++; if (y !== e) begin errors++; $display("FAIL rstmid_state_ch%0d: got %0d want %0d", c, y, e); end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_ch     = '0;
    bus.b0        = '0;
    bus.b1        = '0;
    bus.b2        = '0;
    bus.a1        = '0;
    bus.a2        = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_passthrough();
    test_recursion();
    test_isolation();
    test_saturation();
    test_backpressure();
    test_clear_midop();
    test_random();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
